// File: rtl/nand_unit_arbiter.sv
// nand_unit_arbiter: shares one WIDTH-bit NAND unit among N_REQ cores.
// Flow: IDLE -> EXEC -> DONE. Operands are latched when the grant is issued.
// The result is registered in EXEC, and done pulses for one cycle in DONE.
// Optional feature: define NAND_ARB_RR_EN for round-robin arbitration.
// When it is undefined, the arbiter uses fixed lowest-index priority.
module nand_unit_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             owner,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic [2:0]         r_owner;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;

  logic               w_win_found;
  logic [2:0]         w_win_idx;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_arb_fire;
  logic               w_busy;

`ifdef NAND_ARB_RR_EN
  logic [2:0]         r_ptr;
`endif

  // Winner selection: the first requester at or above ptr, then wrapping below it (round-robin), or the lowest set index (fixed priority).
  always_comb begin
    w_win_found  = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
`ifdef NAND_ARB_RR_EN
    // The rotated scan is split into two ascending passes so every req index is a loop constant.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_win_found && req[k] && (k >= 32'(r_ptr))) begin
        w_win_found     = 1'b1;
        w_win_idx       = 3'(k);
        w_win_onehot[k] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_win_found && req[k] && (k < 32'(r_ptr))) begin
        w_win_found     = 1'b1;
        w_win_idx       = 3'(k);
        w_win_onehot[k] = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_win_found && req[k]) begin
        w_win_found     = 1'b1;
        w_win_idx       = 3'(k);
        w_win_onehot[k] = 1'b1;
      end
    end
`endif
  end

  // Operand mux: route the winner's slices of a_in/b_in toward the operand registers.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (32'(w_win_idx) == k) begin
        w_sel_a = a_in[k*WIDTH +: WIDTH];
        w_sel_b = b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register, synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: arbitrate only in IDLE, then walk through EXEC and DONE unconditionally.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_win_found) w_next_state = EXEC;
      EXEC:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: busy whenever not IDLE; the arbitration fires on an IDLE cycle with any request.
  always_comb begin
    w_busy     = (r_state != IDLE);
    w_arb_fire = (r_state == IDLE) && w_win_found;
  end

  // Datapath registers: grant/owner/operands on arbitration, result/done in EXEC, release in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_done   <= '0;
      r_owner  <= '0;
      r_result <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_fire) begin
            r_grant <= w_win_onehot;
            r_owner <= w_win_idx;
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
          end
        end
        EXEC: begin
          r_result <= ~(r_op_a & r_op_b);
          r_done   <= r_grant;
        end
        DONE: begin
          r_done  <= '0;
          r_grant <= '0;
        end
        default: begin
          r_done  <= '0;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef NAND_ARB_RR_EN
  // Round-robin pointer: on each grant, move to the index after the winner, wrapping at N_REQ-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_arb_fire) begin
      if (32'(w_win_idx) == (N_REQ - 1)) r_ptr <= '0;
      else                               r_ptr <= w_win_idx + 3'd1;
    end
  end
`endif

  assign grant  = r_grant;
  assign owner  = r_owner;
  assign done   = r_done;
  assign result = r_result;
  assign busy   = w_busy;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Directed self-checking bench for nand_unit_arbiter (N_REQ=4, WIDTH=8).
// Expectations follow NAND_ARB_RR_EN when it is defined for the build.
module tb_nand_unit_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   grant;
  logic [2:0]     owner;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;

  int n_tests;
  int n_fail;

  nand_unit_arbiter #(.N_REQ(N), .WIDTH(W)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .grant  (grant),
    .owner  (owner),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from an IDLE cycle: E0 grant, E1 done/result, E2 release.
  task automatic do_op(input string tag, input logic [N-1:0] rq, input int w,
                       input logic [W-1:0] res);
    logic [N-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    req = rq;
    tick();
    check({tag, ".grant"}, 32'(grant), 32'(oh));
    check({tag, ".owner"}, 32'(owner), 32'(w));
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    tick();
    check({tag, ".done"},   32'(done),   32'(oh));
    check({tag, ".result"}, 32'(result), 32'(res));
    tick();
    check({tag, ".rel"}, 32'({grant, done, busy}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    req  = '0;
    a_in = '0;
    b_in = '0;
    do_reset();

    check("rst.grant",  32'(grant),  32'd0);
    check("rst.done",   32'(done),   32'd0);
    check("rst.owner",  32'(owner),  32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.busy",   32'(busy),   32'd0);

    // No request: stays idle.
    tick();
    check("idle.busy", 32'(busy), 32'd0);

    // Single request, core 0.
    a_in[0*W +: W] = 8'hF0; b_in[0*W +: W] = 8'hCC;
    do_op("single", 4'b0001, 0, 8'h3F);
    req = '0;
    a_in[0*W +: W] = 8'hFF; b_in[0*W +: W] = 8'hFF;
    do_op("ones", 4'b0001, 0, 8'h00);
    req = '0;
    a_in[1*W +: W] = 8'h00; b_in[1*W +: W] = 8'hA5;
    do_op("zeros", 4'b0010, 1, 8'hFF);
    req = '0;

    // Contention with distinct per-core operands; b=FF so the result is ~a.
    do_reset();
    a_in = {8'h33, 8'h22, 8'h11, 8'h00};
    b_in = '1;
`ifdef NAND_ARB_RR_EN
    do_op("rr0", 4'b1111, 0, 8'hFF);
    do_op("rr1", 4'b1111, 1, 8'hEE);
    do_op("rr2", 4'b1111, 2, 8'hDD);
    do_op("rr3", 4'b1111, 3, 8'hCC);
    do_op("rrwrap", 4'b1111, 0, 8'hFF);
`else
    for (int i = 0; i < 4; i++) begin
      do_op("fix", 4'b1010, 1, 8'hEE);
    end
`endif
    req = '0;

    // Operand and request changes after the latch edge are ignored.
    a_in[2*W +: W] = 8'h0F; b_in[2*W +: W] = 8'h0F;
    req = 4'b0100;
    tick();
    check("late.grant", 32'(grant), 32'h4);
    a_in = '1;
    req  = '0;
    tick();
    check("late.done",   32'(done),   32'h4);
    check("late.result", 32'(result), 32'hF0);
    tick();
    check("late.rel", 32'({grant, done, busy}), 32'd0);
    tick();
    check("late.idle", 32'(busy), 32'd0);

    // Reset during EXEC aborts the operation; the pointer returns to 0.
    b_in = '1;
    a_in = {8'h33, 8'h22, 8'h11, 8'h00};
    req = 4'b0100;
    tick();
    check("abort.grant", 32'(grant), 32'h4);
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.done",   32'(done),   32'd0);
    check("abort.grant0", 32'(grant),  32'd0);
    check("abort.busy",   32'(busy),   32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.owner",  32'(owner),  32'd0);
    tick();
    check("abort.nodone", 32'(done), 32'd0);
    do_op("post", 4'b1111, 0, 8'hFF);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
